// File: rtl/lut_neuron_prog_if.sv
// Configuration and lookup signals of the programmable LUT neuron.
// The master side is the configuration sequencer or requester; the slave side is the neuron.
interface lut_neuron_prog_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
);
    logic                cfg_start;
    logic                cfg_valid;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_ready;
    logic                cfg_done;
    logic                armed;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic                drop;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
        input  cfg_ready, cfg_done, armed, out_valid, out_data, drop
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
        output cfg_ready, cfg_done, armed, out_valid, out_data, drop
    );
endinterface

// File: rtl/lut_neuron_prog.sv
// Runtime-loadable LUT neuron: the truth table is streamed in over valid/ready,
// then served through a one-cycle registered lookup port.
module lut_neuron_prog #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    lut_neuron_prog_if.slave      bus
);
    localparam int DEPTH = 2 ** IN_BITS;
    localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

    state_t               state_reg;
    logic [IN_BITS:0]     addr_reg;
    logic                 cfg_ready_reg;
    logic                 cfg_done_reg;
    logic                 armed_reg;
    logic                 out_valid_reg;
    logic                 drop_reg;
    logic [OUT_BITS-1:0]  out_data_reg;

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] table_mem [DEPTH];

    logic beat_ok;
    logic last_beat;
    logic lookup_ok;

    // A restart in the same cycle as a beat wins, so that beat is never written.
    assign beat_ok   = (state_reg == LOAD) && bus.cfg_valid && !bus.cfg_start;
    assign last_beat = beat_ok && (addr_reg == LAST_ADDR);
    assign lookup_ok = bus.in_valid && armed_reg;

    always_ff @(posedge clk) begin
        if (beat_ok) begin
            table_mem[addr_reg[IN_BITS-1:0]] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            cfg_ready_reg <= 1'b0;
            cfg_done_reg  <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            cfg_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cfg_start) begin
                        state_reg     <= LOAD;
                        addr_reg      <= '0;
                        cfg_ready_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.cfg_start) begin
                        addr_reg <= '0;
                    end else if (beat_ok) begin
                        addr_reg <= addr_reg + 1'b1;
                        if (last_beat) begin
                            state_reg     <= ARMED;
                            cfg_ready_reg <= 1'b0;
                            armed_reg     <= 1'b1;
                            cfg_done_reg  <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (bus.cfg_start) begin
                        state_reg     <= LOAD;
                        addr_reg      <= '0;
                        cfg_ready_reg <= 1'b1;
                        armed_reg     <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    addr_reg      <= '0;
                    cfg_ready_reg <= 1'b0;
                    armed_reg     <= 1'b0;
                end
            endcase
        end
    end

    // armed_reg is still high in the cycle a reload starts, so that lookup completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= lookup_ok;
            drop_reg      <= bus.in_valid && !armed_reg;
            if (lookup_ok) begin
                out_data_reg <= table_mem[bus.in_data];
            end
        end
    end

    assign bus.cfg_ready = cfg_ready_reg;
    assign bus.cfg_done  = cfg_done_reg;
    assign bus.armed     = armed_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.drop      = drop_reg;
endmodule

// File: tb/tb_lut_neuron_prog.sv
// Directed bench for lut_neuron_prog: a table-level model predicts every output each
// cycle, and literal checks pin the key scenarios.
module tb_lut_neuron_prog;
    logic clk = 1'b0;
    logic rst = 1'b0;

    lut_neuron_prog_if #(.IN_BITS(8), .OUT_BITS(2)) bus ();

    lut_neuron_prog #(.IN_BITS(8), .OUT_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int done_count = 0;

    // Model: table contents, load progress and the outputs expected after each edge.
    int       m_mem [256];
    bit       m_loading;
    int       m_count;
    bit       m_armed;
    logic     exp_ready, exp_done, exp_armed, exp_valid, exp_drop;
    logic [1:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 1'b0;
            m_count   = 0;
            m_armed   = 1'b0;
            exp_ready = 1'b0;
            exp_done  = 1'b0;
            exp_armed = 1'b0;
            exp_valid = 1'b0;
            exp_drop  = 1'b0;
            exp_data  = 2'b00;
        end else begin
            exp_valid = 1'b0;
            exp_drop  = 1'b0;
            exp_done  = 1'b0;
            if (bus.in_valid) begin
                if (m_armed) begin
                    exp_valid = 1'b1;
                    exp_data  = 2'(m_mem[int'(bus.in_data)]);
                end else begin
                    exp_drop = 1'b1;
                end
            end
            if (bus.cfg_start) begin
                m_loading = 1'b1;
                m_count   = 0;
                m_armed   = 1'b0;
            end else if (m_loading && bus.cfg_valid) begin
                m_mem[m_count] = int'(bus.cfg_data);
                m_count++;
                if (m_count == 256) begin
                    m_loading = 1'b0;
                    m_armed   = 1'b1;
                    exp_done  = 1'b1;
                end
            end
            exp_ready = m_loading;
            exp_armed = m_armed;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_ready", 32'(bus.cfg_ready), 32'(exp_ready));
            check("cmp_done",  32'(bus.cfg_done),  32'(exp_done));
            check("cmp_armed", 32'(bus.armed),     32'(exp_armed));
            check("cmp_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("cmp_drop",  32'(bus.drop),      32'(exp_drop));
            check("cmp_data",  32'(bus.out_data),  32'(exp_data));
            if (bus.cfg_done === 1'b1) done_count++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
    endtask

    task automatic load_beats(input int n, input logic [1:0] val, input bit use_index, output int ready_cycles);
        ready_cycles = 0;
        for (int i = 0; i < n; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = use_index ? 2'(i) : val;
            if (bus.cfg_ready === 1'b1) ready_cycles++;
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] addr);
        bus.in_valid = 1'b1;
        bus.in_data  = addr;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int rc;
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        check("rst_ready", 32'(bus.cfg_ready), 32'd0);
        check("rst_armed", 32'(bus.armed), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data), 32'd0);

        // Pre-arm lookup is dropped.
        lookup(8'h49);
        check("prearm_drop",  32'(bus.drop), 32'd1);
        check("prearm_valid", 32'(bus.out_valid), 32'd0);
        check("prearm_data",  32'(bus.out_data), 32'd0);

        // Full load with index pattern.
        start_pulse();
        load_beats(256, 2'b00, 1'b1, rc);
        check("load_ready_cycles", 32'(rc), 32'd256);
        check("load_done_pulse", 32'(bus.cfg_done), 32'd1);
        check("load_armed", 32'(bus.armed), 32'd1);
        @(negedge clk);
        check("load_done_gone", 32'(bus.cfg_done), 32'd0);

        // Back-to-back lookup sweep.
        for (int i = 0; i < 256; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("sweep_last_valid", 32'(bus.out_valid), 32'd1);
        check("sweep_last_data",  32'(bus.out_data), 32'd3);
        lookup(8'h06);
        check("sweep_0x06", 32'(bus.out_data), 32'd2);

        // Restart mid-load.
        done_count = 0;
        start_pulse();
        load_beats(100, 2'b11, 1'b0, rc);
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 2'b11;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        load_beats(256, 2'b01, 1'b0, rc);
        lookup(8'h10);
        check("restart_0x10", 32'(bus.out_data), 32'd1);
        lookup(8'hF0);
        check("restart_0xF0", 32'(bus.out_data), 32'd1);
        lookup(8'h00);
        check("restart_0x00", 32'(bus.out_data), 32'd1);
        @(negedge clk);
        check("restart_done_once", 32'(done_count), 32'd1);

        // Reload while armed with an in-flight lookup.
        start_pulse();
        load_beats(256, 2'b10, 1'b0, rc);
        bus.cfg_start = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h0A;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        bus.in_data   = 8'h0B;
        check("inflight_valid", 32'(bus.out_valid), 32'd1);
        check("inflight_data",  32'(bus.out_data), 32'd2);
        check("inflight_armed", 32'(bus.armed), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("after_drop",  32'(bus.drop), 32'd1);
        check("after_valid", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset mid-load.
        start_pulse();
        load_beats(50, 2'b01, 1'b0, rc);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(bus.cfg_ready), 32'd0);
        check("arst_armed", 32'(bus.armed), 32'd0);
        check("arst_done",  32'(bus.cfg_done), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_data",  32'(bus.out_data), 32'd0);
        check("arst_drop",  32'(bus.drop), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lookup(8'h20);
        check("arst_after_drop",  32'(bus.drop), 32'd1);
        check("arst_after_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
